// File: rtl/instr_prefetch_queue_if.sv
// Bundle of the fetch-stage buses: instruction-memory req/ack, the IR
// valid/ready handshake toward decode and the branch redirect from execute.
// master: the prefetch queue itself. slave: memory/decode/execute side.
interface instr_prefetch_queue_if;
  // Instruction memory
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  // Decode
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_ready;
  // Execute
  logic        redirect;
  logic [15:0] redirect_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output ir_valid,
    output ir_data,
    output ir_pc,
    input  ir_ready,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  ir_valid,
    input  ir_data,
    input  ir_pc,
    output ir_ready,
    output redirect,
    output redirect_pc
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch over a variable-latency
// req/ack memory port, a DEPTH-entry {pc, instr} FIFO feeding decode, and
// branch redirect with flush. At most one memory request is outstanding.
//
// Optional feature macro: FETCH_BYPASS_EN. When defined, an ack arriving
// while the FIFO is empty is forwarded to decode combinationally in the ack
// cycle (and only written into the FIFO if decode does not take it).
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input logic                     clock,
  input logic                     reset_n,
  instr_prefetch_queue_if.master  bus_io
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DepthCount = PW'(DEPTH);

  typedef enum logic [1:0] {StFetch, StWait, StDiscard} state_e;

  state_e        state_q;
  logic [15:0]   fetch_pc_q;
  logic [15:0]   target_q;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count;
  logic [31:0]   fifo_q [DEPTH];

  logic [15:0]   ir_pc_q, ir_data_q;
  logic [31:0]   head_d;

  logic          fifo_empty;
  logic          credit;
  logic          issue;
  logic          ack_accept;
  logic          bypass;
  logic          push;
  logic          pop;

  // Occupancy and handshake qualifiers. Redirect dominates every push/pop.
  always_comb begin
    count      = wptr_q - rptr_q;
    fifo_empty = (count == '0);
    // Free slot exists for the one request we may open; since only one request
    // is ever outstanding, an ack can never find the FIFO full.
    credit     = (count < DepthCount);
    issue      = (state_q == StFetch) && credit && !bus_io.redirect;
    ack_accept = (state_q == StWait) && bus_io.imem_ack && !bus_io.redirect;
  end

`ifdef FETCH_BYPASS_EN
  // Empty FIFO cannot be popping, so the ack word can go straight to decode.
  assign bypass = ack_accept && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push = ack_accept && !(bypass && bus_io.ir_ready);
  assign pop  = !fifo_empty && bus_io.ir_ready && !bus_io.redirect;

  // Next-state pointers and the registered head (IR) value.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    head_d = {ir_pc_q, ir_data_q};
    if (bus_io.redirect) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      if (ack_accept && fifo_empty) begin
        // Arriving word becomes the head (or, when bypassed and consumed, the
        // last value decode saw, which IR must then hold).
        head_d = {fetch_pc_q, bus_io.imem_rdata};
      end else if (wptr_d != rptr_d) begin
        // The new head may be the entry being written this very cycle.
        if (push && (rptr_d == wptr_q)) begin
          head_d = {fetch_pc_q, bus_io.imem_rdata};
        end else begin
          head_d = fifo_q[rptr_d[AW-1:0]];
        end
      end
      // FIFO drains to empty: IR holds its last value.
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wptr_q[AW-1:0]] <= {fetch_pc_q, bus_io.imem_rdata};
  end

  // Pointers and IR head registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ir_pc_q   <= '0;
      ir_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ir_pc_q   <= head_d[31:16];
      ir_data_q <= head_d[15:0];
    end
  end

  // Fetch FSM: owns the fetch address and the saved redirect target.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
    end else begin
      case (state_q)
        StFetch: begin
          if (bus_io.redirect) begin
            fetch_pc_q <= bus_io.redirect_pc;
          end else if (credit) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (bus_io.redirect) begin
            if (bus_io.imem_ack) begin
              // Ack consumed and dropped; nothing left in flight.
              fetch_pc_q <= bus_io.redirect_pc;
              state_q    <= StFetch;
            end else begin
              // Old request still owed an ack; remember where to go after it.
              target_q <= bus_io.redirect_pc;
              state_q  <= StDiscard;
            end
          end else if (bus_io.imem_ack) begin
            fetch_pc_q <= fetch_pc_q + PC_STEP;
            state_q    <= StFetch;
          end
        end
        StDiscard: begin
          if (bus_io.imem_ack) begin
            fetch_pc_q <= bus_io.redirect ? bus_io.redirect_pc : target_q;
            state_q    <= StFetch;
          end else if (bus_io.redirect) begin
            target_q <= bus_io.redirect_pc;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  // Memory request: opens in FETCH, held through WAIT/DISCARD until ack.
  // Gated by reset_n so the request drops in the same cycle reset asserts.
  assign bus_io.imem_req  = reset_n &&
                            (issue || (state_q == StWait) || (state_q == StDiscard));
  assign bus_io.imem_addr = fetch_pc_q;

  // Decode side.
  assign bus_io.ir_valid = !fifo_empty || bypass;
  assign bus_io.ir_data  = bypass ? bus_io.imem_rdata : ir_data_q;
  assign bus_io.ir_pc    = bypass ? fetch_pc_q : ir_pc_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: table-driven startup vectors, directed
// corner sequences and a randomized run against a stream-level model.
module tb_instr_prefetch_queue;

  localparam int unsigned Depth = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  instr_prefetch_queue_if bus ();

  instr_prefetch_queue #(
    .DEPTH    (Depth),
    .RESET_PC (16'h0000),
    .PC_STEP  (16'd2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus_io  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // ---------------- memory model ----------------
  int          mem_lat   = 1;
  bit          lat_rand  = 1'b0;
  bit          mem_busy  = 1'b0;
  int          mem_wait  = 0;
  logic [15:0] mem_addr  = '0;
  logic [15:0] addr_log[$];
  int          ack_count = 0;

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_busy && reset_n) begin
        mem_wait--;
        bus.imem_ack = (mem_wait == 0);
        if (mem_wait == 0) bus.imem_rdata = mem_addr ^ 16'hA5A5;
      end else begin
        bus.imem_ack = 1'b0;
      end
      @(negedge clock);
      if (!reset_n) begin
        mem_busy = 1'b0;
      end else if (bus.imem_ack) begin
        check("mem_ack_hold", {bus.imem_req, bus.imem_addr}, {1'b1, mem_addr});
        mem_busy = 1'b0;
        ack_count++;
      end else if (mem_busy) begin
        check("mem_req_hold", {bus.imem_req, bus.imem_addr}, {1'b1, mem_addr});
      end else if (bus.imem_req) begin
        mem_busy = 1'b1;
        mem_wait = lat_rand ? int'($urandom_range(1, 4)) : mem_lat;
        mem_addr = bus.imem_addr;
        addr_log.push_back(bus.imem_addr);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  // Leaves the caller just after the posedge where reset released (cycle 0).
  task automatic do_reset(input int lat, input bit ready);
    reset_n         = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.ir_ready    = ready;
    mem_lat         = lat;
    lat_rand        = 1'b0;
    repeat (2) @(posedge clock);
    addr_log.delete();
    ack_count = 0;
    #2 reset_n = 1'b1;
  endtask

  function automatic logic [49:0] outs();
    return {bus.imem_req, bus.imem_addr, bus.ir_valid, bus.ir_pc, bus.ir_data};
  endfunction

  typedef struct {
    logic        ready;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    bit          ok;
    bit          found;
    logic [15:0] exp_pc;
    logic [15:0] hold_pc, hold_data;
    bit          hold;
    int          deliveries;
    logic [15:0] got_pc[$];
    logic [15:0] got_data[$];
    logic [15:0] want_pc[4];

    bus.ir_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // Reset state while reset_n is low.
    #1;
    check("reset_state", outs(), 50'h0);

    // ---- zero-wait startup, table-driven ----
    vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'hA5A5};
    vecs[3] = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'hA5A5};
    vecs[4] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'hA5A7};
    vecs[5] = '{1'b1, 1'b1, 16'h0004, 1'b0, 16'h0002, 16'hA5A7};
    vecs[6] = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'hA5A1};
    vecs[7] = '{1'b1, 1'b1, 16'h0006, 1'b0, 16'h0004, 16'hA5A1};
    do_reset(1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) next_cyc();
      bus.ir_ready = vecs[i].ready;
      sample();
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].pc, vecs[i].data});
    end
    check("startup_nreq", addr_log.size(), 4);
    for (int i = 0; i < addr_log.size(); i++) begin
      check($sformatf("startup_addr%0d", i), addr_log[i], 16'(2 * i));
    end

    // ---- fill with decode stalled, latency 3, then drain ----
    do_reset(3, 1'b0);
    ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k != 0) next_cyc();
      sample();
      if (bus.ir_valid && (bus.ir_pc != 16'h0000 || bus.ir_data != 16'hA5A5)) ok = 1'b0;
    end
    check("full_acks", ack_count, Depth);
    check("full_state", {bus.imem_req, bus.ir_valid, bus.ir_pc, bus.ir_data},
          {1'b0, 1'b1, 16'h0000, 16'hA5A5});
    check("full_hold", ok, 1'b1);
    next_cyc();
    bus.ir_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) next_cyc();
      sample();
      check($sformatf("drain%0d", k), {bus.ir_valid, bus.ir_pc, bus.ir_data},
            {1'b1, 16'(2 * k), 16'(2 * k) ^ 16'hA5A5});
    end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (addr_log.size() >= 5) found = 1'b1;
      else begin
        next_cyc();
        sample();
      end
    end
    check("resume_found", found, 1'b1);
    if (found) check("resume_addr", addr_log[4], 16'h0008);

    // ---- redirect in WAIT, ack two cycles later is dropped ----
    do_reset(3, 1'b1);
    next_cyc();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    sample();
    check("t3_in_wait", {bus.imem_req, bus.imem_addr}, {1'b1, 16'h0000});
    ok = 1'b1;
    for (int k = 2; k <= 7; k++) begin
      next_cyc();
      bus.redirect = 1'b0;
      sample();
      if (bus.ir_valid) ok = 1'b0;
    end
    check("t3_no_valid", ok, 1'b1);
    check("t3_nreq", addr_log.size(), 2);
    if (addr_log.size() >= 2) check("t3_addr", addr_log[1], 16'h0040);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      next_cyc();
      sample();
      if (bus.ir_valid) found = 1'b1;
    end
    check("t3_first", {found, bus.ir_pc, bus.ir_data}, {1'b1, 16'h0040, 16'h0040 ^ 16'hA5A5});

    // ---- redirect coinciding with ack and pop ----
    do_reset(1, 1'b0);
    for (int k = 0; k < 5; k++) next_cyc();
    bus.ir_ready    = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    sample();
    check("t4_pre", {bus.imem_ack, bus.ir_valid}, {1'b1, 1'b1});
    next_cyc();
    bus.redirect = 1'b0;
    sample();
    check("t4_after", {bus.ir_valid, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, 16'h0100});
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      next_cyc();
      sample();
      if (bus.ir_valid) found = 1'b1;
    end
    check("t4_first", {found, bus.ir_pc, bus.ir_data}, {1'b1, 16'h0100, 16'h0100 ^ 16'hA5A5});

    // ---- PC wrap after redirect to 0xFFFC ----
    do_reset(1, 1'b1);
    next_cyc();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFC;
    next_cyc();
    bus.redirect = 1'b0;
    got_pc.delete();
    got_data.delete();
    for (int k = 0; k < 40 && got_pc.size() < 4; k++) begin
      if (k != 0) next_cyc();
      sample();
      if (bus.ir_valid && bus.ir_ready) begin
        got_pc.push_back(bus.ir_pc);
        got_data.push_back(bus.ir_data);
      end
    end
    want_pc = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
    check("wrap_count", got_pc.size(), 4);
    for (int i = 0; i < got_pc.size() && i < 4; i++) begin
      check($sformatf("wrap%0d", i), {got_pc[i], got_data[i]},
            {want_pc[i], want_pc[i] ^ 16'hA5A5});
    end

    // ---- reset asserted mid-WAIT ----
    do_reset(4, 1'b0);
    for (int k = 0; k < 11; k++) next_cyc();
    @(posedge clock);
    #2;
    check("t6_pre", {bus.imem_req, bus.imem_addr, bus.ir_valid, bus.ir_data},
          {1'b1, 16'h0004, 1'b1, 16'hA5A5});
    #1 reset_n = 1'b0;
    #1;
    check("t6_reset_out", outs(), 50'h0);
    do_reset(1, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      sample();
      if (addr_log.size() >= 1) found = 1'b1;
      else next_cyc();
    end
    check("t6_found", found, 1'b1);
    if (found) check("t6_first_addr", addr_log[0], 16'h0000);

    // ---- randomized run against the stream model ----
    // Decode must see consecutive PCs from the latest redirect target (or
    // RESET_PC), each with the word memory returns for that address.
    do_reset(1, 1'b1);
    lat_rand   = 1'b1;
    exp_pc     = 16'h0000;
    hold       = 1'b0;
    hold_pc    = '0;
    hold_data  = '0;
    deliveries = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) next_cyc();
      bus.ir_ready    = ($urandom_range(0, 9) < 6);
      bus.redirect    = ($urandom_range(0, 24) == 0);
      bus.redirect_pc = 16'($urandom) & 16'hFFFE;
      sample();
      if (hold) begin
        check("rand_hold", {bus.ir_valid, bus.ir_pc, bus.ir_data}, {1'b1, hold_pc, hold_data});
      end
      if (bus.redirect) begin
        exp_pc = bus.redirect_pc;
      end else if (bus.ir_valid && bus.ir_ready) begin
        check("rand_deliver", {bus.ir_pc, bus.ir_data}, {exp_pc, exp_pc ^ 16'hA5A5});
        exp_pc = exp_pc + 16'd2;
        deliveries++;
      end
      hold      = bus.ir_valid && !bus.ir_ready && !bus.redirect;
      hold_pc   = bus.ir_pc;
      hold_data = bus.ir_data;
    end
    check("rand_liveness", (deliveries > 200), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle 16-bit datapath.
- Generates sequential fetch addresses and issues them to instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned 16-bit instruction words and their PCs in a small FIFO, and presents them to decode as IR with a valid/ready handshake.
- Accepts branch redirects from execute, flushing all queued and in-flight instructions.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- RESET_PC, 16'h0000: first fetch address after reset.
- PC_STEP, 2: byte increment between sequential 16-bit instructions.

Ports:
- clock, input, 1: sole clock; all state updates on posedge.
- reset_n, input, 1: asynchronous active-low reset.
- imem_req, output, 1: fetch request to instruction memory.
- imem_addr, output, 16: fetch byte address; stable while imem_req=1.
- imem_ack, input, 1: one-cycle pulse; imem_rdata valid in this cycle.
- imem_rdata, input, 16: returned instruction word.
- ir_valid, output, 1: FIFO head holds a valid instruction.
- ir_data, output, 16: instruction at FIFO head (IR).
- ir_pc, output, 16: byte address of ir_data.
- ir_ready, input, 1: decode consumes the head on a cycle where ir_valid & ir_ready.
- redirect, input, 1: branch taken; flush and refetch.
- redirect_pc, input, 16: new fetch address, sampled when redirect=1.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir_data=0, ir_pc=0.
  - FIFO count=0, fetch_pc=RESET_PC, state=FETCH.
- FSM state FETCH:
  - imem_req=1 when (count + 0) < DEPTH; otherwise imem_req=0 and the FSM stays in FETCH.
  - The req/ack handshake opens when imem_req goes high; advance to WAIT.
- FSM state WAIT:
  - imem_req stays 1 and imem_addr=fetch_pc is held until imem_ack.
  - On ack: write {fetch_pc, imem_rdata} to the FIFO tail, set fetch_pc += PC_STEP (16-bit wrap: 16'hFFFE + 2 = 16'h0000), and return to FETCH.
  - Request the next address in the cycle after ack; at most one request is outstanding.
- FSM state DISCARD:
  - Entered when redirect arrives in WAIT without a same-cycle ack.
  - imem_req stays 1 with the old address until ack; that ack's data is dropped.
  - Then go to FETCH with fetch_pc = the saved redirect_pc.
- Credit rule: a request is issued only when count < DEPTH, counting the outstanding slot, so an ack never finds the FIFO full.
- Dequeue:
  - On ir_valid & ir_ready, the head pops and the next entry appears on the following cycle.
  - Pop and push in the same cycle are both honoured and count is unchanged.
- Output stability: ir_data and ir_pc hold while ir_valid=1 & ir_ready=0. After the head pops with the FIFO empty, ir_valid=0 and ir_data/ir_pc hold their last value.
- Redirect (highest priority, takes effect in the same cycle):
  - FIFO cleared (count=0, ir_valid=0 next cycle); any push or pop in that cycle is ignored.
  - From FETCH: fetch_pc = redirect_pc, state stays FETCH, and the first new request comes the next cycle.
  - From WAIT with simultaneous ack: the ack is dropped, fetch_pc = redirect_pc, state goes to FETCH.
  - From DISCARD: redirect_pc overwrites the saved target.
- Latency: with zero-wait memory (ack the cycle after req), the first ir_valid rises 2 cycles after reset release (request cycle, ack cycle), registered.
- Reset mid-transaction: all state clears immediately. Memory must tolerate a dropped request.
- Pointers: read and write pointers are log2(DEPTH)+1 bits wide and wrap naturally.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty, not popping, and an ack is accepted, imem_rdata and fetch_pc drive ir_data/ir_pc combinationally with ir_valid=1 in the ack cycle. The entry is written to the FIFO only if ir_ready=0 that cycle. Redirect still suppresses the bypass.
- Undefined: ir_valid/ir_data/ir_pc come only from FIFO registers, and the minimum ack-to-ir_valid latency is 1 cycle.

Test Plan:
- Zero-wait memory returning imem_rdata = addr ^ 16'hA5A5, ir_ready=1 from reset: imem_addr sequence 0,2,4,6. ir_pc follows 0,2,4 with ir_data = 16'hA5A5, 16'hA5A7, 16'hA5A1.
- ir_ready=0, memory acks after 3 cycles: exactly DEPTH=4 acks, then imem_req=0. ir_data/ir_pc stay at 16'hA5A5/0. Raising ir_ready drains 4 entries in 4 cycles, then fetching resumes at addr 8.
- Redirect to 16'h0040 while in WAIT (ack arrives 2 cycles later): ack data is dropped, ir_valid=0, next imem_addr=16'h0040, first ir_pc=16'h0040.
- Redirect to 16'h0100 in the same cycle as an ack and a pop: no push and no pop take effect, count=0, next request addr=16'h0100.
- Redirect_pc=16'hFFFC with zero-wait memory: ir_pc sequence FFFC, FFFE, 0000, 0002.
- reset_n pulled low mid-WAIT at an arbitrary point: outputs go to reset values in the same cycle. After release, the first imem_addr is 16'h0000 (RESET_PC).
